c880_query_harness: RTL and testbench
=====================================

Name: c880_query_harness

Overview:
- Sequential test/oracle harness that sits directly upstream and downstream of the c880-class combinational benchmark.
- Accepts one input pattern per query over a valid/ready request channel and drives it onto the benchmark primary inputs.
- Waits a fixed settle time, then captures the benchmark primary outputs.
- Returns pattern plus response over a valid/ready response channel. Optionally checks the response against an expected value and keeps query/mismatch statistics.

Parameters:
- IN_W, 60, width of benchmark primary-input vector (G1..G60, bit 0 = G1)
- OUT_W, 26, width of benchmark primary-output vector (G855..G880, bit 0 = G855)
- SETTLE, 2, cycles between driving dut_pi and capturing dut_po; legal range 1..15
- CNT_W, 16, width of statistic counters

Ports:
- CK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- req_valid  in  1  query request valid
- req_ready  out  1  harness can accept a query
- req_pattern  in  IN_W  input vector to apply
- req_expect  in  OUT_W  expected response
- req_chk  in  1  compare response against req_expect
- dut_pi  out  IN_W  registered drive to benchmark inputs
- dut_po  in  OUT_W  benchmark outputs (combinational return)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_pattern  out  IN_W  pattern that produced the response
- rsp_response  out  OUT_W  captured dut_po
- rsp_mismatch  out  1  req_chk was set and response != expect
- busy  out  1  state != IDLE
- clr_stats  in  1  synchronous clear of counters
- query_cnt  out  CNT_W  completed response handshakes, wraps
- mismatch_cnt  out  CNT_W  mismatching checked queries, saturates at all-ones

Behaviour:
- Reset (RST_N=0 at edge):
  - state=IDLE.
  - dut_pi, rsp_pattern, rsp_response, expect/chk registers, wait counter, query_cnt and mismatch_cnt all 0.
  - rsp_valid=0, rsp_mismatch=0.
  - Reset mid-query aborts the query silently; no response is produced.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge N: dut_pi<=req_pattern, latch req_expect/req_chk, wait counter<=SETTLE-1, go WAIT.
- WAIT:
  - req_ready=0. Counter decrements each edge while nonzero.
  - At the edge where counter==0 (edge N+SETTLE):
    - rsp_response<=dut_po, rsp_pattern<=dut_pi.
    - rsp_mismatch<=chk & (dut_po!=expect).
    - Go RESP.
    - mismatch_cnt increments (saturating) when the captured mismatch is 1.
  - rsp_valid is high first in the cycle after edge N+SETTLE.
- RESP:
  - rsp_valid=1; all rsp_* fields held stable until rsp_ready.
  - On rsp_valid&rsp_ready edge: query_cnt+1 (wrapping), go IDLE.
  - req_ready is not asserted in the same cycle, so minimum query period is SETTLE+2 cycles.
- dut_pi holds the last applied pattern after the query completes; it changes only on acceptance or reset.
- dut_po is sampled only at the capture edge; glitches at other times are ignored.
- clr_stats:
  - Clears both counters at the edge, in any state.
  - If it coincides with a counter increment, clear wins (result 0).
  - Does not affect the query in flight.
- req_valid while not in IDLE is ignored. Requesters keep it asserted (valid/ready rule: no drop before acceptance).
- SETTLE outside 1..15 is a elaboration error.

Decomposition:
- Shared package c880_harness_pkg: state enum (IDLE/WAIT/RESP), default widths (IN_W=60, OUT_W=26), SETTLE_MAX constant.
- One natural sub-module: harness_sat_counter (CNT_W, inc, clr, wrap/saturate select), instantiated for query_cnt (wrap) and mismatch_cnt (saturate).
- Benchmark instance stays outside the harness; top-level test wrapper connects dut_pi/dut_po.

Test Plan:
- Bench uses stub dut_po = dut_pi[OUT_W-1:0] ^ 26'h3FFFFFF (except scenario 5).
- Basic query: SETTLE=2, req_pattern=60'h0, req_chk=0 at edge 10.
  - Required: rsp_valid high after edge 12.
  - rsp_response=26'h3FFFFFF, rsp_mismatch=0.
  - query_cnt=1 after the handshake.
- Check mismatch: pattern=60'h000_0000_0000_0001, expect=26'h3FFFFFE, chk=1 -> rsp_mismatch=0.
  - Repeat with expect=0 -> rsp_mismatch=1, mismatch_cnt=1.
- Backpressure: hold rsp_ready=0 for 5 cycles.
  - Required: rsp_* stable, req_ready=0, a second req_valid is not accepted.
  - Release: query_cnt increments once, req_ready returns 1 next cycle.
- Reset mid-WAIT: RST_N=0 one cycle after acceptance.
  - Required: rsp_valid never rises, dut_pi=0, counters 0, req_ready=1 after reset.
- Glitch/settle: SETTLE=4; stub changes dut_po to 26'h1555555 only at cycle N+2, then to 26'h2AAAAAA at N+3.
  - Required: rsp_response=26'h2AAAAAA.
- Counters: drive 2^CNT_W+1 queries -> query_cnt=1.
  - Force 2^CNT_W+2 mismatches -> mismatch_cnt=16'hFFFF.
  - clr_stats coincident with a mismatch capture -> mismatch_cnt=0.

Source files
------------

// File: rtl/c880_harness_pkg.sv
// Shared widths, limits and FSM state encodings for the c880 query harness.
package c880_harness_pkg;
   localparam int DEF_IN_W   = 60;
   localparam int DEF_OUT_W  = 26;
   localparam int SETTLE_MAX = 15;
   localparam int WAIT_W     = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;
endpackage

// File: rtl/c880_query_harness_sat_counter.sv
// Statistic counter with synchronous clear; wraps or saturates at all-ones.
module harness_sat_counter #(
   parameter int CNT_W    = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic             CK,
   input  logic             RST_N,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      // Clear has priority over a coincident increment.
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && !(SATURATE && (cnt_q == {CNT_W{1'b1}})))
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge CK) begin
      if (!RST_N) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/c880_query_harness.sv
// Query harness around a c880-class combinational block: apply pattern, settle, capture, respond.
//   state   | meaning
//   IDLE    | ready for a query; dut_pi holds the last pattern
//   WAIT    | pattern applied, counting down the settle time
//   RESP    | response captured, held until rsp_ready
module c880_query_harness
   import c880_harness_pkg::*;
#(
   parameter int IN_W   = DEF_IN_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic             CK,
   input  logic             RST_N,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IN_W-1:0]  req_pattern,
   input  logic [OUT_W-1:0] req_expect,
   input  logic             req_chk,
   output logic [IN_W-1:0]  dut_pi,
   input  logic [OUT_W-1:0] dut_po,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [IN_W-1:0]  rsp_pattern,
   output logic [OUT_W-1:0] rsp_response,
   output logic             rsp_mismatch,
   output logic             busy,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] query_cnt,
   output logic [CNT_W-1:0] mismatch_cnt
);
   generate
      if ((SETTLE < 1) || (SETTLE > SETTLE_MAX)) begin : g_bad_settle
         $error("c880_query_harness: SETTLE must be within 1..15");
      end
   endgenerate

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [IN_W-1:0]    pi_q, pi_d, rpat_q, rpat_d;
   logic [OUT_W-1:0]   exp_q, exp_d, resp_q, resp_d;
   logic               chk_q, chk_d, mis_q, mis_d;
   logic               mis_now, cap_mis, rsp_hs;

   assign mis_now = chk_q && (dut_po != exp_q);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      pi_d    = pi_q;
      exp_d   = exp_q;
      chk_d   = chk_q;
      rpat_d  = rpat_q;
      resp_d  = resp_q;
      mis_d   = mis_q;
      cap_mis = 1'b0;
      rsp_hs  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               pi_d    = req_pattern;
               exp_d   = req_expect;
               chk_d   = req_chk;
               wait_d  = WAIT_W'(SETTLE - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_q != '0) begin
               wait_d = wait_q - WAIT_W'(1);
            end else begin
               // dut_po is only looked at on this edge; earlier glitches never land.
               resp_d  = dut_po;
               rpat_d  = pi_q;
               mis_d   = mis_now;
               cap_mis = mis_now;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_hs  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CK) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
         pi_q    <= '0;
         exp_q   <= '0;
         chk_q   <= 1'b0;
         rpat_q  <= '0;
         resp_q  <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         pi_q    <= pi_d;
         exp_q   <= exp_d;
         chk_q   <= chk_d;
         rpat_q  <= rpat_d;
         resp_q  <= resp_d;
         mis_q   <= mis_d;
      end
   end

   harness_sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_query_cnt (
      .CK(CK), .RST_N(RST_N), .inc_i(rsp_hs), .clr_i(clr_stats), .cnt_o(query_cnt)
   );

   harness_sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_mismatch_cnt (
      .CK(CK), .RST_N(RST_N), .inc_i(cap_mis), .clr_i(clr_stats), .cnt_o(mismatch_cnt)
   );

   assign req_ready    = (state_q == ST_IDLE);
   assign rsp_valid    = (state_q == ST_RESP);
   assign busy         = (state_q != ST_IDLE);
   assign dut_pi       = pi_q;
   assign rsp_pattern  = rpat_q;
   assign rsp_response = resp_q;
   assign rsp_mismatch = mis_q;
endmodule

// File: tb/tb_c880_query_harness.sv
// Directed bench for c880_query_harness: XOR stub on the main instance, scripted dut_po on a SETTLE=4 instance.
module tb_c880_query_harness;
   localparam int IN_W  = 60;
   localparam int OUT_W = 26;
   localparam int CW    = 4;   // narrow counters keep wrap/saturate runs short

   logic             CK = 1'b0;
   logic             RST_N;
   logic             req_valid, req_chk, rsp_ready, clr_stats;
   logic [IN_W-1:0]  req_pattern;
   logic [OUT_W-1:0] req_expect;
   logic             req_ready, rsp_valid, rsp_mismatch, busy;
   logic [IN_W-1:0]  dut_pi, rsp_pattern;
   logic [OUT_W-1:0] dut_po, rsp_response;
   logic [CW-1:0]    query_cnt, mismatch_cnt;

   logic             req_valid4, rsp_ready4;
   logic             req_ready4, rsp_valid4, rsp_mismatch4, busy4;
   logic [IN_W-1:0]  dut_pi4, rsp_pattern4;
   logic [OUT_W-1:0] po4, rsp_response4;
   logic [15:0]      query_cnt4, mismatch_cnt4;

   int total = 0;
   int bad   = 0;
   int lat;

   always #5 CK = ~CK;

   assign dut_po = dut_pi[OUT_W-1:0] ^ 26'h3FFFFFF;

   c880_query_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(2), .CNT_W(CW)) dut (
      .CK(CK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready),
      .req_pattern(req_pattern), .req_expect(req_expect), .req_chk(req_chk),
      .dut_pi(dut_pi), .dut_po(dut_po), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_pattern(rsp_pattern), .rsp_response(rsp_response), .rsp_mismatch(rsp_mismatch),
      .busy(busy), .clr_stats(clr_stats), .query_cnt(query_cnt), .mismatch_cnt(mismatch_cnt)
   );

   c880_query_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(4), .CNT_W(16)) dut4 (
      .CK(CK), .RST_N(RST_N), .req_valid(req_valid4), .req_ready(req_ready4),
      .req_pattern(req_pattern), .req_expect(req_expect), .req_chk(req_chk),
      .dut_pi(dut_pi4), .dut_po(po4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
      .rsp_pattern(rsp_pattern4), .rsp_response(rsp_response4), .rsp_mismatch(rsp_mismatch4),
      .busy(busy4), .clr_stats(clr_stats), .query_cnt(query_cnt4), .mismatch_cnt(mismatch_cnt4)
   );

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [IN_W-1:0] p, input logic [OUT_W-1:0] e, input logic c);
      req_pattern = p;
      req_expect  = e;
      req_chk     = c;
      req_valid   = 1'b1;
      tick();
      req_valid   = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic query(input logic [IN_W-1:0] p, input logic [OUT_W-1:0] e, input logic c);
      int n;
      send(p, e, c);
      wait_rsp(n);
      if (n != 2) check("query_latency", 64'(n), 64'd2);
      handshake();
   endtask

   initial begin
      RST_N = 1'b0; req_valid = 1'b0; req_chk = 1'b0; rsp_ready = 1'b0; clr_stats = 1'b0;
      req_pattern = '0; req_expect = '0; req_valid4 = 1'b0; rsp_ready4 = 1'b0; po4 = '0;
      tick(); tick();
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_dut_pi", 64'(dut_pi), 64'd0);
      check("rst_rsp_response", 64'(rsp_response), 64'd0);
      check("rst_counts", 64'({query_cnt, mismatch_cnt}), 64'd0);
      RST_N = 1'b1;
      tick();

      // Basic query
      send(60'h0, 26'h0, 1'b0);
      check("basic_busy", 64'(busy), 64'd1);
      check("basic_ready_low", 64'(req_ready), 64'd0);
      wait_rsp(lat);
      check("basic_latency", 64'(lat), 64'd2);
      check("basic_response", 64'(rsp_response), 64'h3FFFFFF);
      check("basic_mismatch", 64'(rsp_mismatch), 64'd0);
      check("basic_pattern", 64'(rsp_pattern), 64'd0);
      handshake();
      check("basic_query_cnt", 64'(query_cnt), 64'd1);
      check("basic_ready_back", 64'(req_ready), 64'd1);

      // Checked queries
      send(60'h1, 26'h3FFFFFE, 1'b1);
      wait_rsp(lat);
      check("chk_match_mis", 64'(rsp_mismatch), 64'd0);
      check("chk_match_cnt", 64'(mismatch_cnt), 64'd0);
      handshake();
      send(60'h1, 26'h0, 1'b1);
      wait_rsp(lat);
      check("chk_miss_mis", 64'(rsp_mismatch), 64'd1);
      check("chk_miss_cnt", 64'(mismatch_cnt), 64'd1);
      handshake();
      check("chk_query_cnt", 64'(query_cnt), 64'd3);

      // Backpressure with a competing request held high
      send(60'hABC, 26'h0, 1'b0);
      wait_rsp(lat);
      req_pattern = 60'h123; req_chk = 1'b0; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 64'(rsp_valid), 64'd1);
         check("bp_response", 64'(rsp_response), 64'h3FFF543);
         check("bp_pattern", 64'(rsp_pattern), 64'hABC);
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_dut_pi", 64'(dut_pi), 64'hABC);
      end
      handshake();
      check("bp_query_cnt", 64'(query_cnt), 64'd4);
      check("bp_ready_back", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      check("bp_second_accept", 64'(dut_pi), 64'h123);
      wait_rsp(lat);
      check("bp_second_resp", 64'(rsp_response), 64'h3FFFEDC);
      handshake();
      check("bp_query_cnt2", 64'(query_cnt), 64'd5);

      // Reset in WAIT
      send(60'hF0F, 26'h0, 1'b1);
      tick();
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check("mrst_dut_pi", 64'(dut_pi), 64'd0);
      check("mrst_counts", 64'({query_cnt, mismatch_cnt}), 64'd0);
      check("mrst_req_ready", 64'(req_ready), 64'd1);
      lat = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid) lat++;
      end
      check("mrst_no_rsp", 64'(lat), 64'd0);

      // Glitching dut_po on the SETTLE=4 instance
      req_pattern = 60'h55; req_valid4 = 1'b1;
      tick();
      req_valid4 = 1'b0;
      tick();
      tick();
      po4 = 26'h1555555;
      tick();
      po4 = 26'h2AAAAAA;
      check("g4_not_yet", 64'(rsp_valid4), 64'd0);
      tick();
      po4 = 26'h0;
      check("g4_valid", 64'(rsp_valid4), 64'd1);
      check("g4_response", 64'(rsp_response4), 64'h2AAAAAA);
      check("g4_pattern", 64'(rsp_pattern4), 64'h55);
      tick();
      check("g4_hold", 64'(rsp_response4), 64'h2AAAAAA);
      rsp_ready4 = 1'b1;
      tick();
      rsp_ready4 = 1'b0;
      check("g4_query_cnt", 64'(query_cnt4), 64'd1);

      // Wrap and saturate on 4-bit counters
      for (int i = 0; i < 17; i++) query(60'h0, 26'h0, 1'b0);
      check("wrap_query_cnt", 64'(query_cnt), 64'd1);
      for (int i = 0; i < 18; i++) query(60'h0, 26'h0, 1'b1);
      check("sat_mismatch_cnt", 64'(mismatch_cnt), 64'hF);
      check("wrap_query_cnt2", 64'(query_cnt), 64'd3);

      // Clear coincident with a mismatch capture, then with a query increment
      send(60'h0, 26'h0, 1'b1);
      tick();
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("clr_valid", 64'(rsp_valid), 64'd1);
      check("clr_rsp_mis", 64'(rsp_mismatch), 64'd1);
      check("clr_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
      check("clr_query_cnt", 64'(query_cnt), 64'd0);
      clr_stats = 1'b1;
      handshake();
      clr_stats = 1'b0;
      check("clr_on_hs", 64'(query_cnt), 64'd0);
      check("clr_idle", 64'(req_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
